// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC, single-outstanding ibus
// sequencing, redirect squashing and a one-entry valid/ready output buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_adel
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_drop, w_drop_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic        r_out_adel, w_out_adel_nxt;
  logic [31:0] r_out_pc, w_out_pc_nxt;
  logic [31:0] r_out_instr, w_out_instr_nxt;

  logic w_aligned;
  logic w_req_hs;
  logic w_adel_load;

  assign w_aligned   = (r_pc[1:0] == 2'b00);
  assign ireq_valid  = resetn && (r_state == S_REQ) && !r_out_valid && w_aligned;
  assign ireq_addr   = r_pc;
  assign w_req_hs    = ireq_valid && ireq_addr_ok;
  assign w_adel_load = (r_state == S_REQ) && !r_out_valid && !w_aligned;

  assign out_valid = r_out_valid;
  assign out_pc    = r_out_pc;
  assign out_instr = r_out_instr;
  assign out_adel  = r_out_adel;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_drop_nxt      = r_drop;
    w_out_valid_nxt = r_out_valid && !out_ready;
    w_out_adel_nxt  = r_out_adel;
    w_out_pc_nxt    = r_out_pc;
    w_out_instr_nxt = r_out_instr;

    if (redirect_valid) begin
      w_pc_nxt        = redirect_pc;
      w_out_valid_nxt = 1'b0;
      w_out_adel_nxt  = 1'b0;
      // A response landing this cycle closes the old request outright;
      // otherwise a request still in flight must be swallowed later.
      if ((r_state == S_WAIT) && iresp_data_ok) begin
        w_state_nxt = S_REQ;
        w_drop_nxt  = 1'b0;
      end else if ((r_state == S_WAIT) || w_req_hs) begin
        w_state_nxt = S_WAIT;
        w_drop_nxt  = 1'b1;
      end
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (w_req_hs) begin
            w_state_nxt = S_WAIT;
          end else if (w_adel_load) begin
            w_out_valid_nxt = 1'b1;
            w_out_adel_nxt  = 1'b1;
            w_out_pc_nxt    = r_pc;
            w_out_instr_nxt = '0;
          end
        end
        S_WAIT: begin
          if (iresp_data_ok) begin
            w_state_nxt = S_REQ;
            if (r_drop) begin
              w_drop_nxt = 1'b0;
            end else begin
              w_out_valid_nxt = 1'b1;
              w_out_adel_nxt  = 1'b0;
              w_out_pc_nxt    = r_pc;
              w_out_instr_nxt = iresp_data;
              w_pc_nxt        = r_pc + 32'd4;
            end
          end
        end
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_drop      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_adel  <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drop      <= w_drop_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_adel  <= w_out_adel_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_out_instr <= w_out_instr_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] B = 32'hbfc0_0000;

  logic        clk;
  logic        resetn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_adel;

  fetch_unit #(.RESET_PC(32'hbfc0_0000)) dut (
    .clk(clk), .resetn(resetn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_addr_ok(ireq_addr_ok),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_adel(out_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Reference model: PC, one in-flight bus transaction with a stale flag,
  // and the Decode-facing entry.
  logic [31:0] m_pc, m_opc, m_oinstr;
  logic        m_inflight, m_stale, m_ov, m_adel;
  logic        model_on = 1'b0;

  logic        c_rst, c_redir, c_aok, c_dok, c_rdy;
  logic [31:0] c_rpc, c_dat;
  logic        s_iv;

  function automatic logic exp_iv();
    return c_rst && !m_inflight && !m_ov && (m_pc[1:0] == 2'b00);
  endfunction

  task automatic model_reset();
    m_pc = B; m_inflight = 0; m_stale = 0;
    m_ov = 0; m_adel = 0; m_opc = '0; m_oinstr = '0;
  endtask

  task automatic model_tick();
    logic hs, resp, oldov;
    if (!c_rst) begin
      model_reset();
    end else begin
      hs    = exp_iv() && c_aok;
      resp  = m_inflight && c_dok;
      oldov = m_ov;
      if (c_redir) begin
        m_pc = c_rpc; m_ov = 0; m_adel = 0;
        if (resp) begin
          m_inflight = 0; m_stale = 0;
        end else if (m_inflight || hs) begin
          m_inflight = 1; m_stale = 1;
        end
      end else begin
        if (oldov && c_rdy) m_ov = 0;
        if (resp) begin
          m_inflight = 0;
          if (m_stale) m_stale = 0;
          else begin
            m_opc = m_pc; m_oinstr = c_dat; m_adel = 0; m_ov = 1; m_pc = m_pc + 32'd4;
          end
        end else if (hs) begin
          m_inflight = 1;
        end else if (!m_inflight && !oldov && m_pc[1:0] != 2'b00) begin
          m_ov = 1; m_adel = 1; m_opc = m_pc; m_oinstr = '0;
        end
      end
    end
  endtask

  // Drive inputs, then sample at the falling edge and compare with the model.
  task automatic apply(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic aok, input logic dok, input logic [31:0] dat,
                       input logic rdy);
    c_rst = rst; c_redir = redir; c_rpc = rpc; c_aok = aok; c_dok = dok; c_dat = dat; c_rdy = rdy;
    resetn = rst; redirect_valid = redir; redirect_pc = rpc;
    ireq_addr_ok = aok; iresp_data_ok = dok; iresp_data = dat; out_ready = rdy;
    @(negedge clk);
    s_iv = ireq_valid;
    if (model_on) begin
      chk("model ireq_valid", {31'd0, ireq_valid}, {31'd0, exp_iv()});
      chk("model ireq_addr", ireq_addr, m_pc);
      chk("model out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      if (m_ov) begin
        chk("model out_pc", out_pc, m_opc);
        chk("model out_instr", out_instr, m_oinstr);
        chk("model out_adel", {31'd0, out_adel}, {31'd0, m_adel});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic c_iv(input string nm, input logic e);
    chk(nm, {31'd0, ireq_valid}, {31'd0, e});
  endtask
  task automatic c_ov(input string nm, input logic e);
    chk(nm, {31'd0, out_valid}, {31'd0, e});
  endtask

  typedef struct {
    logic        aok, dok, rdy;
    logic [31:0] dat;
    logic        eiv;
    logic [31:0] eaddr;
    logic        eov;
    logic [31:0] eopc, einstr;
  } vec_t;

  function automatic vec_t mk(input logic aok, input logic dok, input logic [31:0] dat,
                              input logic rdy, input logic eiv, input logic [31:0] eaddr,
                              input logic eov, input logic [31:0] eopc, input logic [31:0] einstr);
    vec_t v;
    v.aok = aok; v.dok = dok; v.dat = dat; v.rdy = rdy;
    v.eiv = eiv; v.eaddr = eaddr; v.eov = eov; v.eopc = eopc; v.einstr = einstr;
    return v;
  endfunction

  vec_t tbl[15];

  logic        bus_pend;
  logic [31:0] bus_addr;
  int unsigned bus_cnt;

  initial begin
    // Reset release, in-order fetch, and 5 cycles of back-pressure.
    tbl[0]  = mk(1, 0, '0,       0, 1, B,       0, '0,      '0);
    tbl[1]  = mk(0, 1, mem(B),   0, 0, B,       0, '0,      '0);
    for (int i = 2; i <= 6; i++)
      tbl[i] = mk(1, 0, '0,      0, 0, B + 4,   1, B,       mem(B));
    tbl[7]  = mk(1, 0, '0,       1, 0, B + 4,   1, B,       mem(B));
    tbl[8]  = mk(1, 0, '0,       0, 1, B + 4,   0, '0,      '0);
    tbl[9]  = mk(0, 1, mem(B+4), 0, 0, B + 4,   0, '0,      '0);
    tbl[10] = mk(1, 0, '0,       1, 0, B + 8,   1, B + 4,   mem(B + 4));
    tbl[11] = mk(1, 0, '0,       0, 1, B + 8,   0, '0,      '0);
    tbl[12] = mk(0, 1, mem(B+8), 0, 0, B + 8,   0, '0,      '0);
    tbl[13] = mk(0, 0, '0,       1, 0, B + 12,  1, B + 8,   mem(B + 8));
    tbl[14] = mk(0, 0, '0,       0, 1, B + 12,  0, '0,      '0);

    model_reset();
    apply(0, 0, '0, 0, 0, '0, 0);
    tick();
    model_on = 1'b1;
    apply(0, 1, 32'h1234_5678, 1, 0, '0, 0);
    c_iv("reset ireq_valid", 0);
    c_ov("reset out_valid", 0);
    chk("reset out_pc", out_pc, '0);
    chk("reset out_instr", out_instr, '0);
    chk("reset out_adel", {31'd0, out_adel}, '0);
    tick();

    for (int i = 0; i < 15; i++) begin
      apply(1, 0, '0, tbl[i].aok, tbl[i].dok, tbl[i].dat, tbl[i].rdy);
      c_iv($sformatf("vec%0d ireq_valid", i), tbl[i].eiv);
      chk($sformatf("vec%0d ireq_addr", i), ireq_addr, tbl[i].eaddr);
      c_ov($sformatf("vec%0d out_valid", i), tbl[i].eov);
      if (tbl[i].eov) begin
        chk($sformatf("vec%0d out_pc", i), out_pc, tbl[i].eopc);
        chk($sformatf("vec%0d out_instr", i), out_instr, tbl[i].einstr);
      end
      tick();
    end

    // Redirect while waiting: in-flight word is swallowed.
    apply(1, 0, '0, 1, 0, '0, 0); c_iv("s3 req", 1); chk("s3 addr", ireq_addr, B + 12); tick();
    apply(1, 1, 32'h8000_1000, 0, 0, '0, 0); c_iv("s3 wait iv", 0); tick();
    apply(1, 0, '0, 0, 1, mem(B + 12), 0); c_iv("s3 drop iv", 0);
    chk("s3 addr after redirect", ireq_addr, 32'h8000_1000); tick();
    apply(1, 0, '0, 1, 0, '0, 0); c_ov("s3 dropped ov", 0); c_iv("s3 new iv", 1);
    chk("s3 new addr", ireq_addr, 32'h8000_1000); tick();
    apply(1, 0, '0, 0, 1, mem(32'h8000_1000), 0); tick();
    apply(1, 0, '0, 0, 0, '0, 1); c_ov("s3 ov", 1);
    chk("s3 out_pc", out_pc, 32'h8000_1000); chk("s3 out_instr", out_instr, mem(32'h8000_1000)); tick();

    // Redirect on the handshake cycle, then on the data cycle.
    apply(1, 1, 32'h8000_2000, 1, 0, '0, 0); c_iv("s4 iv", 1); chk("s4 addr", ireq_addr, 32'h8000_1004); tick();
    apply(1, 0, '0, 0, 1, mem(32'h8000_1004), 0); c_iv("s4 wait iv", 0); tick();
    apply(1, 0, '0, 1, 0, '0, 0); c_ov("s4 dropped ov", 0); c_iv("s4 new iv", 1);
    chk("s4 new addr", ireq_addr, 32'h8000_2000); tick();
    apply(1, 1, 32'h8000_3000, 0, 1, mem(32'h8000_2000), 0); tick();
    apply(1, 0, '0, 0, 0, '0, 0); c_ov("s4 dok-redir ov", 0); c_iv("s4 no extra wait", 1);
    chk("s4 dok-redir addr", ireq_addr, 32'h8000_3000); tick();

    // Misaligned target produces an address-error entry.
    apply(1, 1, 32'h8000_0002, 0, 0, '0, 0); tick();
    apply(1, 0, '0, 1, 0, '0, 0); c_iv("s5 misaligned iv", 0); c_ov("s5 pre ov", 0); tick();
    apply(1, 0, '0, 1, 0, '0, 0); c_ov("s5 adel ov", 1);
    chk("s5 adel flag", {31'd0, out_adel}, 32'd1); chk("s5 adel pc", out_pc, 32'h8000_0002);
    chk("s5 adel instr", out_instr, '0); c_iv("s5 adel iv", 0); tick();
    apply(1, 1, 32'h8000_0000, 1, 0, '0, 0); c_ov("s5 held ov", 1); tick();
    apply(1, 0, '0, 1, 0, '0, 0); c_ov("s5 cleared ov", 0); c_iv("s5 resume iv", 1);
    chk("s5 resume addr", ireq_addr, 32'h8000_0000); tick();
    apply(1, 0, '0, 0, 1, mem(32'h8000_0000), 0); tick();
    apply(1, 0, '0, 0, 0, '0, 1); c_ov("s5 fetch ov", 1);
    chk("s5 fetch pc", out_pc, 32'h8000_0000); chk("s5 fetch adel", {31'd0, out_adel}, '0); tick();

    // Reset mid-WAIT with a stale response arriving during reset.
    apply(1, 0, '0, 1, 0, '0, 0); chk("s6 addr", ireq_addr, 32'h8000_0004); tick();
    apply(0, 0, '0, 0, 0, '0, 0); c_iv("s6 rst iv", 0); tick();
    apply(0, 1, 32'h8000_5000, 0, 1, mem(32'h8000_0004), 0);
    c_ov("s6 rst ov", 0); c_iv("s6 rst iv2", 0); tick();
    apply(1, 0, '0, 1, 0, '0, 0); c_iv("s6 first iv", 1); chk("s6 first addr", ireq_addr, B);
    c_ov("s6 no stale ov", 0); tick();
    apply(1, 0, '0, 0, 1, mem(B), 0); c_ov("s6 wait ov", 0); tick();
    apply(1, 0, '0, 0, 0, '0, 1); c_ov("s6 ov", 1); chk("s6 out_pc", out_pc, B);
    chk("s6 out_instr", out_instr, mem(B)); tick();

    // Randomized traffic with a variable-latency bus.
    bus_pend = 0; bus_addr = '0; bus_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        r_rst, r_redir, r_aok, r_dok, r_rdy;
      logic [31:0] r_rpc, r_dat, r_rnd;
      r_rst   = ($urandom_range(0, 99) != 0);
      r_redir = ($urandom_range(0, 15) == 0);
      r_rnd   = $urandom;
      r_rpc   = {r_rnd[31:2], ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      r_aok   = ($urandom_range(0, 2) != 0);
      r_dok   = bus_pend && (bus_cnt == 0);
      r_dat   = r_dok ? mem(bus_addr) : $urandom;
      r_rdy   = ($urandom_range(0, 3) != 0);
      apply(r_rst, r_redir, r_rpc, r_aok, r_dok, r_dat, r_rdy);
      if (!r_rst || r_dok) bus_pend = 0;
      else if (bus_pend) bus_cnt--;
      if (r_rst && s_iv && r_aok) begin
        bus_pend = 1; bus_addr = ireq_addr; bus_cnt = $urandom_range(0, 2);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
